residue_check_mod3: RTL and testbench

Sequential mod-3 residue checker: the receiving end of the mod-3 residue code. It accepts a DW-bit data word with its 2-bit residue over a valid/ready handshake and recomputes the residue one nibble per cycle. It then reports match or mismatch over an output handshake and keeps a sticky error flag plus a saturating error counter. It sits after the residue generator and the protected datapath, and feeds the fault-injection campaign's detection statistics.

---
 rtl/residue_pkg.sv | 31 +++
 rtl/mod3_nibble_acc.sv | 50 +++++
 rtl/residue_check_mod3.sv | 128 ++++++++++++
 tb/tb_residue_check_mod3.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/residue_pkg.sv
// Shared types and helpers for the mod-3 residue checker.
package residue_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        REPORT
    } state_t;

    localparam logic [1:0] RES_INVALID = 2'b11;

    localparam int unsigned GID_NIB0_SUM   = 0;
    localparam int unsigned GID_NIB0_CARRY = 1;
    localparam int unsigned GID_NIB1_SUM   = 2;
    localparam int unsigned GID_NIB1_CARRY = 3;
    localparam int unsigned GID_ACC_B0     = 4;
    localparam int unsigned GID_ACC_B1     = 5;

    // Accepts any 2-bit operands (including 3, reachable under faults).
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= 3'd6) begin
            t = t - 3'd6;
        end else if (t >= 3'd3) begin
            t = t - 3'd3;
        end
        return t[1:0];
    endfunction

endpackage

// File: rtl/mod3_nibble_acc.sv
// One nibble folded into the running mod-3 accumulator.
// Fault-override gates are compiled in only when FAULT_INJ_EN is defined.
module mod3_nibble_acc
    import residue_pkg::*;
#(
    parameter int unsigned NG       = 128,
    parameter int unsigned GID_BASE = 0
) (
    input  logic [3:0]    nibble,
    input  logic [1:0]    acc,
    input  logic [NG-1:0] fault_en_bus,
    input  logic          fault_val,
    output logic [1:0]    acc_next
);

    // Nibble weights are 1,2,1,2 mod 3, so sum the two bit pairs and fold
    // the carry back in (4 is congruent to 1 mod 3).
    logic [2:0] st0_raw;
    logic [1:0] st0_sum;
    logic       st0_carry;
    logic [2:0] st1_raw;
    logic [1:0] st1_sum;
    logic       st1_carry;
    logic [1:0] nib_res;
    logic [1:0] acc_raw;
    logic       unused_fault;

    assign st0_raw = {1'b0, nibble[1:0]} + {1'b0, nibble[3:2]};
    assign st1_raw = {1'b0, st0_sum} + {2'b00, st0_carry};
    assign nib_res = mod3_add(st1_sum, {1'b0, st1_carry});
    assign acc_raw = mod3_add(acc, nib_res);

`ifdef FAULT_INJ_EN
    assign st0_sum    = fault_en_bus[GID_BASE + GID_NIB0_SUM]   ? {2{fault_val}} : st0_raw[1:0];
    assign st0_carry  = fault_en_bus[GID_BASE + GID_NIB0_CARRY] ? fault_val      : st0_raw[2];
    assign st1_sum    = fault_en_bus[GID_BASE + GID_NIB1_SUM]   ? {2{fault_val}} : st1_raw[1:0];
    assign st1_carry  = fault_en_bus[GID_BASE + GID_NIB1_CARRY] ? fault_val      : st1_raw[2];
    assign acc_next[0] = fault_en_bus[GID_BASE + GID_ACC_B0]    ? fault_val      : acc_raw[0];
    assign acc_next[1] = fault_en_bus[GID_BASE + GID_ACC_B1]    ? fault_val      : acc_raw[1];
`else
    assign st0_sum   = st0_raw[1:0];
    assign st0_carry = st0_raw[2];
    assign st1_sum   = st1_raw[1:0];
    assign st1_carry = st1_raw[2];
    assign acc_next  = acc_raw;
`endif

    assign unused_fault = ^{fault_en_bus, fault_val};

endmodule

// File: rtl/residue_check_mod3.sv
// Sequential mod-3 residue checker: one nibble per cycle, handshaked report,
// sticky error flag and saturating error count. Fault gates: FAULT_INJ_EN.
module residue_check_mod3
    import residue_pkg::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned NG       = 128,
    parameter int unsigned GID_BASE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [1:0]       in_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ok,
    output logic [1:0]       out_calc_res,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_err,
    input  logic [NG-1:0]    fault_en_bus,
    input  logic             fault_val
);

    localparam int unsigned NN    = DW / 4;
    localparam int unsigned IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);

    state_t          state;
    state_t          state_nx;
    logic [DW-1:0]   data_q;
    logic [1:0]      res_q;
    logic [1:0]      acc;
    logic [1:0]      acc_next;
    logic [IDX_W-1:0] idx;
    logic            last_nib;
    logic            err_event;

    assign last_nib  = (idx == IDX_LAST);
    assign err_event = out_valid && out_ready && !out_ok;

    mod3_nibble_acc #(
        .NG       (NG),
        .GID_BASE (GID_BASE)
    ) u_nib (
        .nibble       (data_q[3:0]),
        .acc          (acc),
        .fault_en_bus (fault_en_bus),
        .fault_val    (fault_val),
        .acc_next     (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)        state_nx = CALC;
            CALC:    if (last_nib)        state_nx = REPORT;
            REPORT:  if (out_ready)       state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == REPORT);
    end

    // The data register shifts right so the current nibble is always [3:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            res_q        <= '0;
            acc          <= '0;
            idx          <= '0;
            out_calc_res <= '0;
            out_ok       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        res_q  <= in_res;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    idx    <= idx + 1'b1;
                    data_q <= data_q >> 4;
                    if (last_nib) begin
                        out_calc_res <= acc_next;
                        out_ok       <= (acc_next == res_q) && (res_q != RES_INVALID);
                    end
                end
                default: ;
            endcase
        end
    end

    // A clear coinciding with an error is applied first, so the error still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (clr_err) begin
            err_sticky <= err_event;
            err_cnt    <= err_event ? CNT_W'(1) : '0;
        end else if (err_event) begin
            err_sticky <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_residue_check_mod3.sv
// Self-checking bench for residue_check_mod3 against an arithmetic mod-3 model.
module tb_residue_check_mod3;

    localparam int unsigned DW       = 16;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned NG       = 128;
    localparam int unsigned GID_BASE = 0;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [1:0]       in_res;
    logic             out_valid;
    logic             out_ready;
    logic             out_ok;
    logic [1:0]       out_calc_res;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic             clr_err;
    logic [NG-1:0]    fault_en_bus;
    logic             fault_val;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic exp_sticky = 1'b0;

    residue_check_mod3 #(
        .DW       (DW),
        .CNT_W    (CNT_W),
        .NG       (NG),
        .GID_BASE (GID_BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_res       (in_res),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ok       (out_ok),
        .out_calc_res (out_calc_res),
        .err_sticky   (err_sticky),
        .err_cnt      (err_cnt),
        .clr_err      (clr_err),
        .fault_en_bus (fault_en_bus),
        .fault_val    (fault_val)
    );

    always #5 clk = ~clk;

    // Error bookkeeping from the model's verdict, not the DUT's.
    function automatic void model_report(input logic ok, input logic clr);
        if (clr) begin
            exp_cnt    = ok ? 0 : 1;
            exp_sticky = !ok;
        end else if (!ok) begin
            exp_sticky = 1'b1;
            if (exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
        end
    endfunction

    task automatic run_word(input logic [DW-1:0] d, input logic [1:0] r, input int hold,
                            input logic clr, output logic [1:0] calc, output logic ok,
                            output int lat, output logic unstable);
        int w;
        unstable = 1'b0;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        in_valid = 1'b1; in_data = d; in_res = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (in_ready !== 1'b0) unstable = 1'b1;
            @(posedge clk); #1; lat++;
        end
        if (w >= 20) lat = 99;
        calc = out_calc_res;
        ok   = out_ok;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_calc_res !== calc || out_ok !== ok || in_ready !== 1'b0)
                unstable = 1'b1;
        end
        out_ready = 1'b1; clr_err = clr;
        @(posedge clk); #1;
        out_ready = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_cnt = 0; exp_sticky = 1'b0;
        checks += 6;
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        if (out_ok !== 1'b0)     begin errors++; $display("FAIL reset_out_ok got=%0b exp=0", out_ok); end
        if (out_calc_res !== 2'd0) begin errors++; $display("FAIL reset_calc got=%0d exp=0", out_calc_res); end
        if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%0b exp=0", err_sticky); end
        if (err_cnt !== '0)      begin errors++; $display("FAIL reset_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_directed;
        logic [DW-1:0] d [3] = '{16'h1234, 16'h1234, 16'hFFFF};
        logic [1:0]    r [3] = '{2'd1, 2'd2, 2'd3};
        logic [1:0] calc; logic ok, uns; int lat;
        int er; logic eok;
        for (int i = 0; i < 3; i++) begin
            er  = int'(d[i]) % 3;
            eok = (int'(r[i]) == er) && (r[i] != 2'b11);
            run_word(d[i], r[i], 0, 1'b0, calc, ok, lat, uns);
            model_report(eok, 1'b0);
            checks += 6;
            if (calc !== 2'(er)) begin errors++; $display("FAIL dir_calc[%0d] got=%0d exp=%0d", i, calc, er); end
            if (ok !== eok)      begin errors++; $display("FAIL dir_ok[%0d] got=%0b exp=%0b", i, ok, eok); end
            if (lat !== DW/4)    begin errors++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, DW/4); end
            if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL dir_cnt[%0d] got=%0d exp=%0d", i, err_cnt, exp_cnt); end
            if (err_sticky !== exp_sticky)   begin errors++; $display("FAIL dir_sticky[%0d] got=%0b exp=%0b", i, err_sticky, exp_sticky); end
            if (uns !== 1'b0)    begin errors++; $display("FAIL dir_ready_low[%0d] got=%0b exp=0", i, uns); end
        end
    endtask

    task automatic test_stall;
        logic [1:0] calc; logic ok, uns; int lat;
        run_word(16'h00A5, 2'd0, 5, 1'b0, calc, ok, lat, uns);
        model_report(1'b1, 1'b0);
        checks += 4;
        if (uns !== 1'b0)      begin errors++; $display("FAIL stall_stable got=%0b exp=0", uns); end
        if (calc !== 2'd0)     begin errors++; $display("FAIL stall_calc got=%0d exp=0", calc); end
        if (ok !== 1'b1)       begin errors++; $display("FAIL stall_ok got=%0b exp=1", ok); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_random;
        logic [DW-1:0] d; logic [1:0] r, calc; logic ok, uns, eok; int lat, er;
        for (int i = 0; i < 40; i++) begin
            d  = DW'($urandom);
            er = int'(d) % 3;
            r  = ($urandom_range(0, 1) == 1) ? 2'(er) : 2'($urandom_range(0, 3));
            eok = (int'(r) == er) && (r != 2'b11);
            run_word(d, r, int'($urandom_range(0, 2)), 1'b0, calc, ok, lat, uns);
            model_report(eok, 1'b0);
            checks += 4;
            if (calc !== 2'(er)) begin errors++; $display("FAIL rnd_calc d=%h got=%0d exp=%0d", d, calc, er); end
            if (ok !== eok)      begin errors++; $display("FAIL rnd_ok d=%h r=%0d got=%0b exp=%0b", d, r, ok, eok); end
            if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt got=%0d exp=%0d", err_cnt, exp_cnt); end
            if (err_sticky !== exp_sticky)   begin errors++; $display("FAIL rnd_sticky got=%0b exp=%0b", err_sticky, exp_sticky); end
        end
    endtask

    task automatic test_saturation;
        logic [1:0] calc; logic ok, uns; int lat;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        exp_cnt = 0; exp_sticky = 1'b0;
        checks += 2;
        if (err_cnt !== '0)      begin errors++; $display("FAIL clr_cnt got=%0d exp=0", err_cnt); end
        if (err_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got=%0b exp=0", err_sticky); end
        for (int i = 0; i < 5; i++) begin
            run_word(16'h1234, 2'd2, 0, (i == 4), calc, ok, lat, uns);
            model_report(1'b0, (i == 4));
            checks += 2;
            if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, err_cnt, exp_cnt); end
            if (err_sticky !== exp_sticky)   begin errors++; $display("FAIL sat_sticky[%0d] got=%0b exp=%0b", i, err_sticky, exp_sticky); end
        end
    endtask

    task automatic test_reset_mid(input int wait_cycles);
        logic seen_valid;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234; in_res = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (wait_cycles) @(posedge clk);
        #1 rst_n = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b1;
        exp_cnt = 0; exp_sticky = 1'b0;
        seen_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        out_ready = 1'b0;
        checks += 4;
        if (seen_valid !== 1'b0) begin errors++; $display("FAIL rstmid_report[%0d] got=%0b exp=0", wait_cycles, seen_valid); end
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL rstmid_ready[%0d] got=%0b exp=1", wait_cycles, in_ready); end
        if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL rstmid_cnt[%0d] got=%0d exp=%0d", wait_cycles, err_cnt, exp_cnt); end
        if (err_sticky !== exp_sticky)   begin errors++; $display("FAIL rstmid_sticky[%0d] got=%0b exp=%0b", wait_cycles, err_sticky, exp_sticky); end
    endtask

`ifdef FAULT_INJ_EN
    task automatic test_fault;
        logic [1:0] calc; logic ok, uns; int lat;
        fault_en_bus = '0;
        fault_en_bus[GID_BASE + 4] = 1'b1;
        fault_val = 1'b1;
        run_word(16'h0000, 2'd0, 0, 1'b0, calc, ok, lat, uns);
        model_report(1'b0, 1'b0);
        fault_en_bus = '0;
        fault_val = 1'b0;
        checks += 3;
        if (calc !== 2'd1) begin errors++; $display("FAIL fault_calc got=%0d exp=1", calc); end
        if (ok !== 1'b0)   begin errors++; $display("FAIL fault_ok got=%0b exp=0", ok); end
        if (err_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL fault_cnt got=%0d exp=%0d", err_cnt, exp_cnt); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_res = '0;
        out_ready = 1'b0; clr_err = 1'b0; fault_en_bus = '0; fault_val = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_saturation();
`ifdef FAULT_INJ_EN
        test_fault();
`endif
        test_reset_mid(2);
        test_reset_mid(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
